bcd_sub_seq: RTL and testbench

BCD_SUB_SEQ -- requirements
Module: bcd_sub_seq

---
 rtl/bcd_sub_seq.sv | 69 ++++++
 tb/tb_bcd_sub_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: two-digit BCD subtractor, one digit per cycle, borrow rippling from units to tens
module bcd_sub_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] Amsd,
    input  logic [3:0] Alsd,
    input  logic [3:0] Bmsd,
    input  logic [3:0] Blsd,
    output logic       busy,
    output logic       done,
    output logic [3:0] Ymsd,
    output logic [3:0] Ylsd,
    output logic       Bout,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, LSD, MSD, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] a_msd, a_lsd, b_msd, b_lsd, y_lsd_int, dig_fix;
    logic       borrow, bad;
    logic [4:0] dig_diff;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next state and status decode
    always_comb begin
        state_nx = state;
        busy     = (state == LSD) || (state == MSD);
        done     = (state == DONE);
        case (state)
            IDLE:    state_nx = start ? LSD : IDLE;
            LSD:     state_nx = MSD;
            MSD:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // one shared digit subtractor; 5-bit result so a negative difference shows in bit 4 before the +10 fix
    always_comb begin
        dig_diff = (state == MSD) ? {1'b0, a_msd} - {1'b0, b_msd} - {4'd0, borrow}
                                  : {1'b0, a_lsd} - {1'b0, b_lsd} - {4'd0, borrow};
        dig_fix  = dig_diff[4] ? dig_diff[3:0] + 4'd10 : dig_diff[3:0];
    end
    // operand capture, units digit, then publish the whole result on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a_msd, a_lsd, b_msd, b_lsd, y_lsd_int} <= '0;
            {borrow, bad}                           <= '0;
            {Ymsd, Ylsd, Bout, err}                 <= '0;
        end else begin
            if (state == IDLE && start) begin
                {a_msd, a_lsd, b_msd, b_lsd} <= {Amsd, Alsd, Bmsd, Blsd};
                borrow <= 1'b0;
                bad    <= (Amsd > 4'd9) || (Alsd > 4'd9) || (Bmsd > 4'd9) || (Blsd > 4'd9);
            end
            if (state == LSD) begin
                y_lsd_int <= dig_fix;
                borrow    <= dig_diff[4];
            end
            if (state == MSD) begin
                Ymsd <= bad ? 4'd0 : dig_fix;
                Ylsd <= bad ? 4'd0 : y_lsd_int;
                Bout <= !bad && dig_diff[4];
                err  <= bad;
            end
        end
    end
endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb_bcd_sub_seq: directed, exhaustive and random checks of bcd_sub_seq against a decimal model
module tb_bcd_sub_seq;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] Amsd = '0, Alsd = '0, Bmsd = '0, Blsd = '0;
    logic       busy, done, Bout, err;
    logic [3:0] Ymsd, Ylsd;
    int         n_cmp = 0, n_bad = 0;
    logic [9:0] prev = '0;

    bcd_sub_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Amsd(Amsd), .Alsd(Alsd), .Bmsd(Bmsd), .Blsd(Blsd),
        .busy(busy), .done(done), .Ymsd(Ymsd), .Ylsd(Ylsd), .Bout(Bout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // call at a negedge in IDLE; returns at a negedge in IDLE
    task automatic run_op(input int am, input int al, input int bm, input int bl);
        int a, b, y;
        logic e, bo;
        logic [3:0] ym, yl;
        e = (am > 9) || (al > 9) || (bm > 9) || (bl > 9);
        a = am * 10 + al;
        b = bm * 10 + bl;
        y = a - b;
        bo = !e && (y < 0);
        if (y < 0) y += 100;
        ym = e ? 4'd0 : 4'(y / 10);
        yl = e ? 4'd0 : 4'(y % 10);
        Amsd = 4'(am); Alsd = 4'(al); Bmsd = 4'(bm); Blsd = 4'(bl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        Amsd = 4'($urandom); Alsd = 4'($urandom); Bmsd = 4'($urandom); Blsd = 4'($urandom);
        chk("busy_n1", busy, 1); chk("done_n1", done, 0);
        @(negedge clk);
        chk("busy_n2", busy, 1); chk("done_n2", done, 0);
        chk("hold", {Ymsd, Ylsd, Bout, err}, prev);
        @(negedge clk);
        chk("done_n3", done, 1); chk("busy_n3", busy, 0);
        chk("ymsd", Ymsd, ym); chk("ylsd", Ylsd, yl); chk("bout", Bout, bo); chk("err", err, e);
        prev = {ym, yl, bo, e};
        @(negedge clk);
        chk("done_idle", done, 0); chk("busy_idle", busy, 0);
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_out", {Ymsd, Ylsd, Bout, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(7, 2, 5, 6);
        run_op(2, 8, 3, 5);
        run_op(0, 0, 0, 1);
        run_op(5, 6, 5, 6);
        run_op(9, 9, 0, 0);
        run_op(7, 10, 5, 6);
        run_op(4, 5, 1, 2);
        // re-pulsed start while busy must be ignored
        Amsd = 4'd7; Alsd = 4'd2; Bmsd = 4'd5; Blsd = 4'd6; start = 1'b1;
        @(negedge clk);
        Amsd = 4'd1; Alsd = 4'd2; Bmsd = 4'd0; Blsd = 4'd1;
        @(negedge clk);
        Amsd = 4'd9; Alsd = 4'd0; Bmsd = 4'd3; Blsd = 4'd3;
        @(negedge clk);
        start = 1'b0;
        chk("rt_done", done, 1);
        chk("rt_res", {Ymsd, Ylsd, Bout, err}, {4'd1, 4'd6, 1'b0, 1'b0});
        @(negedge clk);
        chk("rt_idle1", {busy, done}, 0);
        @(negedge clk);
        chk("rt_idle2", {busy, done}, 0);
        prev = {4'd1, 4'd6, 2'b00};
        // reset during MSD aborts the operation
        Amsd = 4'd2; Alsd = 4'd8; Bmsd = 4'd3; Blsd = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0); chk("ar_done", done, 0);
        chk("ar_out", {Ymsd, Ylsd, Bout, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_nodone1", {busy, done}, 0);
        @(negedge clk);
        chk("ar_nodone2", {busy, done}, 0);
        prev = '0;
        run_op(4, 5, 1, 2);
        for (int a = 0; a < 100; a++)
            for (int b = 0; b < 100; b++)
                run_op(a / 10, a % 10, b / 10, b % 10);
        for (int i = 0; i < 300; i++)
            run_op($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
